exec_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the single shared execute unit (ALU with add / branch-compare, `alu_src` mux, branch-taken `jump` output).
- Fetches an instruction over a req/ack instruction port and decodes it.
- Drives the exec controls (`aluop`, `alu_src`, `branch`) and sequences the data-memory access and register write-back.
- Owns the PC. Sits between the instruction/data memory ports, the register file and the exec block.

---
 rtl/exec_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_exec_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle sequencer: fetch, decode, exec, data access and write-back around one shared exec unit.
// Handshake: a req stays high until its ack is sampled on a rising edge; an ack while req is low is ignored.
module exec_seq_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] imm,
  output logic [11:0] aluop,
  output logic        alu_src,
  output logic        branch,
  input  logic        jump,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        rf_wsel,
  output logic [31:0] pc,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, res_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q, rf_we_q;
  logic        branch_q, alu_src_q, illegal_q, halted_q;

  logic [5:0]  opcode;
  logic        is_r, is_addi, is_lw, is_sw, is_bnez, is_j, is_legal;
  logic [31:0] imm_d, pc_inc_d, br_target_d, j_target_d;

  assign opcode   = ir_q[31:26];
  assign is_r     = (opcode == 6'h00);
  assign is_addi  = (opcode == 6'h08);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_bnez  = (opcode == 6'h05);
  assign is_j     = (opcode == 6'h02);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_bnez | is_j;

  // All PC arithmetic wraps modulo 2^32 through plain 32-bit adds.
  assign imm_d       = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_inc_d    = pc_q + 32'd4;
  assign br_target_d = pc_inc_d + {imm_d[29:0], 2'b00};
  assign j_target_d  = {pc_inc_d[31:28], ir_q[25:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      res_q      <= 32'h0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      branch_q   <= 1'b0;
      alu_src_q  <= 1'b0;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          // Coming out of reset the request is raised here; every later entry raises it on the way in.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ack) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_j) begin
            pc_q       <= j_target_d;
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end else if (!is_legal) begin
            illegal_q <= 1'b1;
            if (HALT_ON_ILLEGAL) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q       <= pc_inc_d;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end
          end else begin
            alu_src_q <= is_addi | is_lw | is_sw;
            branch_q  <= is_bnez;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q     <= alu_result;
          alu_src_q <= 1'b0;
          branch_q  <= 1'b0;
          if (is_bnez) begin
            pc_q       <= jump ? br_target_d : pc_inc_d;
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end else if (is_lw || is_sw) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_sw;
            state_q    <= S_MEM;
          end else begin
            rf_we_q <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_sw) begin
              pc_q       <= pc_inc_d;
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              rf_we_q <= 1'b1;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q       <= pc_inc_d;
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign rs_addr   = ir_q[25:21];
  assign rt_addr   = ir_q[20:16];
  assign imm       = imm_d;
  assign aluop     = {ir_q[31:26], ir_q[5:0]};
  assign alu_src   = alu_src_q;
  assign branch    = branch_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign dmem_addr = res_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = is_r ? ir_q[15:11] : ir_q[20:16];
  assign rf_wsel   = is_lw;
  assign pc        = pc_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl: drivers feed instructions/acks, a negedge monitor checks
// fetches, data accesses and write-backs against expected queues filled by the stimulus.
module tb_exec_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rs_addr, rt_addr, rf_waddr;
  logic [31:0] imm, alu_result, dmem_addr, pc;
  logic [11:0] aluop;
  logic        alu_src, branch, jump, dmem_req, dmem_we, dmem_ack;
  logic        rf_we, rf_wsel, illegal, halted;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] exp_fetch_q[$];
  logic [5:0]  exp_wb_q[$];
  logic [32:0] exp_mem_q[$];

  always #5 clk = ~clk;

  exec_seq_ctrl #(.RESET_PC(32'h0000_0100), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .aluop(aluop),
    .alu_src(alu_src), .branch(branch), .jump(jump), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
    .pc(pc), .illegal(illegal), .halted(halted), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [32:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Monitor: pops one expectation per observed handshake or write strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) fail_now("unexpected_fetch", {1'b0, imem_addr});
        else check("fetch_addr", {1'b0, imem_addr}, {1'b0, exp_fetch_q.pop_front()});
      end
      if (dmem_req && dmem_ack) begin
        if (exp_mem_q.size() == 0) fail_now("unexpected_dmem", {dmem_we, dmem_addr});
        else check("dmem_we_addr", {dmem_we, dmem_addr}, exp_mem_q.pop_front());
      end
      if (rf_we) begin
        if (exp_wb_q.size() == 0) fail_now("unexpected_rf_we", {27'h0, rf_waddr, rf_wsel});
        else check("wb_waddr_wsel", {27'h0, rf_waddr, rf_wsel}, {27'h0, exp_wb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_imem();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    if (!imem_req) fail_now("imem_req_timeout", {32'h0, imem_req});
  endtask

  // Presents one instruction; returns one cycle later, i.e. in DECODE.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] instr);
    wait_imem();
    exp_fetch_q.push_back(addr);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, state %0d", dbg_state);
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ack = 1'b1; imem_rdata = 32'h2022_0005;
    jump = 1'b0; alu_result = 32'h0; dmem_ack = 1'b0;

    // Reset with imem_ack tied high
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_strobes", {dmem_req, dmem_we, rf_we, branch, alu_src}, 0);
    check("rst_flags", {illegal, halted}, 0);
    check("rst_pc", pc, 32'h100);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("first_imem_req", imem_req, 1);
    check("first_imem_addr", imem_addr, 32'h100);
    check("first_strobes", {dmem_req, dmem_we, rf_we, branch, alu_src}, 0);
    exp_fetch_q.push_back(32'h100);
    tick();
    imem_ack = 1'b0;

    // ADDI r2, r1, 5
    check("addi_rs_rt", {rs_addr, rt_addr}, {5'd1, 5'd2});
    check("addi_imm", imm, 32'h5);
    alu_result = 32'h6;
    tick();
    check("addi_exec_alu_src", alu_src, 1);
    check("addi_exec_branch", branch, 0);
    check("addi_aluop", aluop, 12'h205);
    exp_wb_q.push_back({5'd2, 1'b0});
    tick();
    check("addi_wb_rf_we", rf_we, 1);
    tick();
    check("addi_after_rf_we", rf_we, 0);
    check("addi_next_req", imem_req, 1);
    check("addi_next_addr", imem_addr, 32'h104);
    check("addi_alu_src_clr", alu_src, 0);

    // LW r3, 8(r1) with dmem_ack in the 3rd MEM cycle
    do_fetch(32'h104, 32'h8C23_0008);
    alu_result = 32'h0000_1234;
    tick();
    check("lw_exec_alu_src", alu_src, 1);
    tick();
    alu_result = 32'hDEAD_BEEF;
    check("lw_mem1_req", {dmem_req, dmem_we}, 2'b10);
    check("lw_mem1_addr", dmem_addr, 32'h1234);
    tick();
    check("lw_mem2_req", {dmem_req, dmem_we}, 2'b10);
    tick();
    check("lw_mem3_req", {dmem_req, dmem_we}, 2'b10);
    exp_mem_q.push_back({1'b0, 32'h0000_1234});
    exp_wb_q.push_back({5'd3, 1'b1});
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("lw_wb_dmem_req", dmem_req, 0);
    check("lw_wb_rf_we", rf_we, 1);
    tick();

    // R-type add r4, r1, r2 with a stray dmem_ack
    do_fetch(32'h108, 32'h0022_2020);
    tick();
    check("r_aluop", aluop, 12'h020);
    check("r_alu_src", alu_src, 0);
    check("r_rs_rt", {rs_addr, rt_addr}, {5'd1, 5'd2});
    exp_wb_q.push_back({5'd4, 1'b0});
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("r_stray_dmem", dmem_req, 0);
    tick();

    // J to 0x200
    do_fetch(32'h10C, 32'h0800_0080);
    tick();
    check("j_pc", pc, 32'h200);

    // BNEZ taken, imm = -2
    do_fetch(32'h200, 32'h1420_FFFE);
    check("bnez_decode_branch", branch, 0);
    jump = 1'b1;
    tick();
    check("bnez_exec_branch", branch, 1);
    check("bnez_exec_alu_src", alu_src, 0);
    check("bnez_imm", imm, 32'hFFFF_FFFE);
    tick();
    jump = 1'b0;
    check("bnez_after_branch", branch, 0);
    check("bnez_taken_pc", pc, 32'h1FC);

    do_fetch(32'h1FC, 32'h0800_0080);
    tick();

    // BNEZ not taken
    do_fetch(32'h200, 32'h1420_FFFE);
    tick();
    tick();
    check("bnez_not_taken_pc", pc, 32'h204);

    // SW zero-wait
    do_fetch(32'h204, 32'hAC25_0004);
    alu_result = 32'h40;
    tick();
    check("sw_exec_alu_src", alu_src, 1);
    tick();
    check("sw_mem_we", {dmem_req, dmem_we}, 2'b11);
    exp_mem_q.push_back({1'b1, 32'h0000_0040});
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("sw_pc", pc, 32'h208);
    check("sw_no_wb", {dmem_req, rf_we}, 0);

    // Far backward branch wraps below zero, then J chain wraps the PC to 0x100
    do_fetch(32'h208, 32'h1420_8000);
    jump = 1'b1;
    tick();
    tick();
    jump = 1'b0;
    check("bnez_far_pc", pc, 32'hFFFE_020C);
    do_fetch(32'hFFFE_020C, 32'h0BFF_FFFF);
    tick();
    check("j_top_pc", pc, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0800_0040);
    tick();
    check("j_wrap_pc", pc, 32'h100);

    // Reset in the middle of an SW data access
    do_fetch(32'h100, 32'hAC25_0004);
    alu_result = 32'h80;
    tick();
    tick();
    check("sw_rst_mem_req", dmem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("sw_rst_drop", {dmem_req, dmem_we}, 0);
    check("sw_rst_pc", pc, 32'h100);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Illegal opcode 0x3F parks in HALT; a stray imem_ack must not restart fetch
    do_fetch(32'h100, 32'hFC00_0000);
    tick();
    check("ill_flags", {illegal, halted}, 2'b11);
    check("ill_imem_req", imem_req, 0);
    imem_ack = 1'b1;
    repeat (4) tick();
    check("halt_imem_req", imem_req, 0);
    check("halt_state", {dbg_state, halted}, {3'd5, 1'b1});
    imem_ack = 1'b0;

    check("fetch_q_drained", exp_fetch_q.size(), 0);
    check("wb_q_drained", exp_wb_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
